// File: rtl/hbs_pkg.sv
// Shared types and limits for the handshake_bus_sync clock-domain crossing.
// Source and destination state encodings plus synchroniser depth bounds.
package hbs_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2
   } src_state_t;

   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_VALID = 2'd1,
      D_ACK   = 2'd2
   } dst_state_t;

   localparam int HBS_SYNC_MIN = 2;
   localparam int HBS_SYNC_MAX = 4;
   localparam int HBS_DROP_W   = 8;

   // Saturating increment for the optional drop counter.
   function automatic logic [HBS_DROP_W-1:0] hbs_sat_inc(input logic [HBS_DROP_W-1:0] v);
      return (v == {HBS_DROP_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/handshake_bus_sync_if.sv
// Word-transfer bundle of handshake_bus_sync: source offer/accept and destination valid/ready.
// master = the agent driving the source side and consuming the destination side; slave = the crossing.
interface handshake_bus_sync_if #(
   parameter int DATA_W = 8
);
   logic              src_valid_i;
   logic [DATA_W-1:0] src_data_i;
   logic              src_ready_o;
   logic              dst_valid_o;
   logic [DATA_W-1:0] dst_data_o;
   logic              dst_ready_i;

   modport master (
      output src_valid_i,
      output src_data_i,
      output dst_ready_i,
      input  src_ready_o,
      input  dst_valid_o,
      input  dst_data_o
   );

   modport slave (
      input  src_valid_i,
      input  src_data_i,
      input  dst_ready_i,
      output src_ready_o,
      output dst_valid_o,
      output dst_data_o
   );
endinterface

// File: rtl/hbs_sync_cell.sv
// Single-bit synchroniser chain: STAGES flops, async active-low reset to 0.
// Latency is STAGES edges of clk; no flow control.
module hbs_sync_cell
   import hbs_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   if (STAGES < HBS_SYNC_MIN || STAGES > HBS_SYNC_MAX) begin : g_bad_stages
      $error("hbs_sync_cell: STAGES out of range");
   end

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/handshake_bus_sync.sv
// Four-phase req/ack word crossing from clk_i to clk_o; one word in flight, destination backpressure unbounded.
// Latency 1 clk_i + SYNC_STAGES+1 clk_o; define HBS_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module handshake_bus_sync
   import hbs_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  clk_o,
   input  logic                  rstn_o,
   handshake_bus_sync_if.slave   bus
`ifdef HBS_DROP_CNT_EN
   ,
   output logic [HBS_DROP_W-1:0] drop_cnt_o
`endif
);

   if (SYNC_STAGES < HBS_SYNC_MIN || SYNC_STAGES > HBS_SYNC_MAX) begin : g_bad_sync
      $error("handshake_bus_sync: SYNC_STAGES out of range");
   end
   if (DATA_W < 1 || DATA_W > 256) begin : g_bad_width
      $error("handshake_bus_sync: DATA_W out of range");
   end

   src_state_t        src_state;
   src_state_t        src_next;
   logic              req_q;
   logic              src_ready_q;
   logic              ack_s;
   logic              accept;
   logic [DATA_W-1:0] hold_q;

   dst_state_t        dst_state;
   dst_state_t        dst_next;
   logic              ack_q;
   logic              req_s;
   logic              load;
   logic              dst_valid_q;
   logic [DATA_W-1:0] dst_data_q;

   // ---------------- source domain ----------------
   assign accept = bus.src_valid_i && src_ready_q;

   always_comb begin
      src_next = src_state;
      case (src_state)
         S_IDLE:  if (accept) src_next = S_REQ;
         S_REQ:   if (ack_s)  src_next = S_ACK;
         S_ACK:   if (!ack_s) src_next = S_IDLE;
         default: src_next = S_IDLE;
      endcase
   end

   // req and ready are flopped from the next state so req leaves the domain glitch-free.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         src_state   <= S_IDLE;
         req_q       <= 1'b0;
         src_ready_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         src_state   <= src_next;
         req_q       <= (src_next == S_REQ);
         src_ready_q <= (src_next == S_IDLE);
         if (accept) begin
            hold_q <= bus.src_data_i;
         end
      end
   end

   assign bus.src_ready_o = src_ready_q;

   hbs_sync_cell #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk  (clk_i),
      .rstn (rstn_i),
      .d    (ack_q),
      .q    (ack_s)
   );

`ifdef HBS_DROP_CNT_EN
   logic [HBS_DROP_W-1:0] drop_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         drop_q <= '0;
      end else if (bus.src_valid_i && !src_ready_q) begin
         drop_q <= hbs_sat_inc(drop_q);
      end
   end

   assign drop_cnt_o = drop_q;
`endif

   // ---------------- destination domain ----------------
   hbs_sync_cell #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk  (clk_o),
      .rstn (rstn_o),
      .d    (req_q),
      .q    (req_s)
   );

   always_comb begin
      dst_next = dst_state;
      load     = 1'b0;
      case (dst_state)
         D_IDLE: begin
            if (req_s) begin
               dst_next = D_VALID;
               load     = 1'b1;
            end
         end
         D_VALID: if (bus.dst_ready_i) dst_next = D_ACK;
         D_ACK:   if (!req_s)          dst_next = D_IDLE;
         default: dst_next = D_IDLE;
      endcase
   end

   // hold_q is quiet from accept until the source sees ack drop, so a plain load is safe here.
   always_ff @(posedge clk_o or negedge rstn_o) begin
      if (!rstn_o) begin
         dst_state   <= D_IDLE;
         ack_q       <= 1'b0;
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         dst_state   <= dst_next;
         ack_q       <= (dst_next == D_ACK);
         dst_valid_q <= (dst_next == D_VALID);
         if (load) begin
            dst_data_q <= hold_q;
         end
      end
   end

   assign bus.dst_valid_o = dst_valid_q;
   assign bus.dst_data_o  = dst_data_q;

endmodule

// File: doc/handshake_bus_sync.md
HANDSHAKE_BUS_SYNC -- requirements
Module: handshake_bus_sync

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of the transferred word, legal range 1..256.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: flops per synchroniser chain, legal range 2..4.
REQ-003 Port clk_i: input, 1 bit; source clock. Port rstn_i: input, 1 bit; source reset, asynchronous, active-low.
REQ-004 Port clk_o: input, 1 bit; destination clock. Port rstn_o: input, 1 bit; destination reset, asynchronous, active-low.
REQ-005 Port src_valid_i: input, 1 bit; the source offers src_data_i.
REQ-006 Port src_data_i: input, DATA_W bits; source word.
REQ-007 Port src_ready_o: output, 1 bit; the source domain can accept a word.
REQ-008 Port dst_valid_o: output, 1 bit; dst_data_o holds a valid word.
REQ-009 Port dst_data_o: output, DATA_W bits; destination word.
REQ-010 Port dst_ready_i: input, 1 bit; the destination consumes the word.

Function
REQ-011 Source accept SHALL occur on a clk_i edge with src_valid_i && src_ready_o; src_data_i is captured into a source holding register on that edge.
REQ-012 The source FSM SHALL have three states:
- S_IDLE: req=0, src_ready_o=1; go to S_REQ on accept.
- S_REQ: req=1, src_ready_o=0; go to S_ACK when synchronised ack=1.
- S_ACK: req=0, src_ready_o=0; go to S_IDLE when synchronised ack=0.
REQ-013 src_ready_o SHALL be a registered decode of S_IDLE and SHALL NOT depend combinationally on src_valid_i.
REQ-014 The holding register SHALL remain stable from accept until return to S_IDLE. It is the only data crossing, and it is never synchronised bitwise.
REQ-015 The destination FSM SHALL have three states:
- D_IDLE: ack=0; on synchronised req=1, load dst_data_o from the holding register and go to D_VALID.
- D_VALID: dst_valid_o=1; on dst_ready_i=1, go to D_ACK.
- D_ACK: ack=1, dst_valid_o=0; on synchronised req=0, go to D_IDLE.
REQ-016 dst_valid_o and dst_data_o SHALL be registered and held unchanged while dst_ready_i=0 (backpressure, unbounded).
REQ-017 Latency from accept to dst_valid_o=1 SHALL be 1 clk_i cycle plus SYNC_STAGES+1 clk_o cycles.
REQ-018 Each accepted word SHALL produce exactly one destination transfer, with no loss and no duplication, when neither reset is asserted.
REQ-019 src_valid_i asserted while src_ready_o=0 SHALL be ignored; the source must hold it, and it is not queued.
REQ-020 When dst_valid_o=1 and dst_ready_i=1 arrive on the same edge that the FSM enters D_VALID, the transfer SHALL complete on that edge.
REQ-021 dst_data_o SHALL retain its last value in D_IDLE and D_ACK.

Reset
REQ-022 While rstn_i=0:
- source FSM = S_IDLE;
- req = 0;
- src_ready_o = 0 during reset, and 1 from the first clk_i edge after release;
- holding register = 0;
- source synchroniser = 0.
REQ-023 While rstn_o=0: destination FSM = D_IDLE, ack=0, dst_valid_o=0, dst_data_o=0, destination synchroniser=0.
REQ-024 A source-only reset mid-transfer SHALL drop the in-flight word. The destination SHALL still complete its current D_VALID transfer, then return to D_IDLE via D_ACK.
REQ-025 A destination-only reset in S_REQ SHALL cause the same word to be re-presented once. This is the documented exception to REQ-018. System-level resets SHALL assert both resets together.

Configuration
REQ-026 With macro HBS_DROP_CNT_EN defined, the block SHALL add output drop_cnt_o (source domain, 8 bits, reset 0).
- drop_cnt_o increments on each clk_i edge with src_valid_i=1 and src_ready_o=0.
- drop_cnt_o saturates at 255.
REQ-027 With HBS_DROP_CNT_EN undefined, drop_cnt_o and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-028 Package hbs_pkg SHALL hold:
- the src_state_t enum (S_IDLE, S_REQ, S_ACK);
- the dst_state_t enum (D_IDLE, D_VALID, D_ACK);
- constants HBS_SYNC_MIN=2 and HBS_SYNC_MAX=4.
REQ-029 Sub-module hbs_sync_cell (parameter STAGES, 1-bit, async active-low reset, reset value 0) SHALL be instantiated twice: once for req into clk_o and once for ack into clk_i.
REQ-030 An elaboration-time check SHALL reject any SYNC_STAGES outside HBS_SYNC_MIN..HBS_SYNC_MAX.

Verification
REQ-031 Basic transfer: DATA_W=8, SYNC_STAGES=2, clk_i 100 MHz, clk_o 37 MHz, dst_ready_i=1, send 0xA5. Required: dst_data_o=0xA5 with dst_valid_o high for one clk_o cycle after 1 clk_i + 3 clk_o cycles, and src_ready_o back to 1.
REQ-032 Backpressure: hold dst_ready_i=0 for 20 clk_o cycles after 0x3C arrives. Required: dst_valid_o and dst_data_o=0x3C stable throughout, src_ready_o=0 throughout, exactly one transfer on release.
REQ-033 Random stream: 1000 random DATA_W=32 words, random dst_ready_i, clock ratios 1:3 and 3:1. Required: the output sequence equals the input sequence, with no loss and no duplicates.
REQ-034 Drop counter (HBS_DROP_CNT_EN defined): hold src_valid_i=1 for 300 clk_i cycles. Required: drop_cnt_o = 255 (saturated); without the macro, no port exists.
REQ-035 Source reset: assert rstn_i in S_REQ. Required: src_ready_o=0 during reset and 1 one clk_i edge after release; the destination completes any pending transfer and returns to D_IDLE; the next word transfers correctly.
